// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the IMEM boot loader.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (adds the trailing checksum byte).
package imem_loader_pkg;

  typedef enum logic [3:0] {
    SYNC,
    CNT0,
    CNT1,
    DATA,
    WRITE,
    CHK,
    DONE,
    RUN,
    ERR
  } state_e;

  localparam logic [7:0]  SYNC_BYTE_DEF   = 8'hA5;
  localparam int          DEPTH_WORDS_DEF = 1024;
  localparam logic [31:0] NOP_INSN        = 32'h00000013;

endpackage

// File: rtl/imem_word_packer.sv
// Byte-lane counter and little-endian placement of four bytes into a 32-bit word.
// word_valid_o pulses combinationally with the byte that fills lane 3.
module imem_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  lane_q, lane_d;
  logic [31:0] word_q, word_d;

  // Next lane and word contents for the byte being accepted.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    lane_d = lane_q;
    word_d = word_q;
    if (clear_i) begin
      lane_d = 2'd0;
    end else if (byte_valid_i) begin
      word_d[{lane_q, 3'b000} +: 8] = byte_i;
      lane_d                        = lane_q + 2'd1;
    end
  end

  // Lane and word registers; the word is cleared so imem_wdata resets to zero.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      lane_q <= 2'd0;
      word_q <= 32'd0;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = byte_valid_i && !clear_i && (lane_q == 2'd3);

endmodule

// File: rtl/imem_loader_ctrl.sv
// Boot-time program loader: parses SYNC/count/data frames from the UART,
// writes assembled words to IMEM and holds the core until a valid image is in.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (trailing mod-256 byte sum).
module imem_loader_ctrl
  import imem_loader_pkg::*;
#(
  parameter int         DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err
);

  localparam logic [16:0] DEPTH_LIM = 17'(DEPTH_WORDS);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] idx_q, idx_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        accept;
  logic [15:0] count_full;
  logic        count_bad;
  logic        last_word;
  logic        pack_clear;
  logic        pack_byte;
  logic        word_valid;

  assign accept     = rx_valid && rx_ready;
  assign count_full = {rx_data, cnt_q[7:0]};
  assign count_bad  = (count_full == 16'd0) || ({1'b0, count_full} > DEPTH_LIM);
  assign last_word  = (idx_q == cnt_q - 16'd1);
  assign pack_clear = (state_q == CNT1) && accept;
  assign pack_byte  = (state_q == DATA) && accept;

  imem_word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (pack_clear),
    .byte_valid_i (pack_byte),
    .byte_i       (rx_data),
    .word_o       (imem_wdata),
    .word_valid_o (word_valid)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;

  // Running mod-256 sum of all data bytes in the current frame.
  always_comb begin
    sum_d = sum_q;
    if (pack_clear)     sum_d = 8'd0;
    else if (pack_byte) sum_d = sum_q + rx_data;
  end

  // Checksum accumulator register.
  always_ff @(posedge clk) begin
    if (rst) sum_q <= 8'd0;
    else     sum_q <= sum_d;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= SYNC;
    else     state_q <= state_d;
  end

  // Next-state logic for the frame parser.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SYNC:  if (accept && rx_data == SYNC_BYTE) state_d = CNT0;
      CNT0:  if (accept) state_d = CNT1;
      CNT1:  if (accept) state_d = count_bad ? ERR : DATA;
      DATA:  if (word_valid) state_d = WRITE;
      WRITE: begin
        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK:   if (accept) state_d = (rx_data == sum_q) ? DONE : ERR;
`endif
      DONE:  state_d = RUN;
      RUN:   if (accept && rx_data == SYNC_BYTE) state_d = CNT0;
      ERR:   state_d = SYNC;
      default: state_d = SYNC;
    endcase
  end

  // Count capture, word index and the sticky done/error flags.
  always_comb begin
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    done_d = done_q;
    err_d  = err_q;
    case (state_q)
      CNT0:  if (accept) cnt_d[7:0] = rx_data;
      CNT1:  if (accept) begin
        cnt_d[15:8] = rx_data;
        idx_d       = 16'd0;
      end
      WRITE: if (!last_word) idx_d = idx_q + 16'd1;
      DONE:  begin
        done_d = 1'b1;
        err_d  = 1'b0;
      end
      RUN:   if (accept && rx_data == SYNC_BYTE) done_d = 1'b0;
      ERR:   begin
        done_d = 1'b0;
        err_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 16'd0;
      idx_q  <= 16'd0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  // State-decoded outputs.
  always_comb begin
    rx_ready = !(state_q == WRITE || state_q == DONE || state_q == ERR);
    imem_we  = (state_q == WRITE);
    cpu_hold = (state_q != RUN);
  end

  assign imem_waddr = {14'd0, idx_q, 2'b00};
  assign load_done  = done_q;
  assign load_err   = err_q;

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Directed bench for imem_loader_ctrl; define IMEM_LOADER_CHECKSUM_EN to match a checksum build.
module tb_imem_loader_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;

  imem_loader_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc     = 0;
  int last_acc = 0;
  logic [63:0] wq[$];
  logic [31:0] fw[$];
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic bad_cs = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every IMEM write as {addr, data}.
  always @(negedge clk) if (imem_we) wq.push_back({imem_waddr, imem_wdata});

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
    @(posedge clk);
    #1;
    last_acc = cyc;
    rx_valid = 1'b0;
  endtask

  // Count bytes, data bytes LSB first, then the checksum when compiled in.
  task automatic send_body();
    logic [15:0] n16;
    logic [7:0]  s;
    logic [31:0] w;
    n16 = 16'(fw.size());
    s   = 8'd0;
    send_byte(n16[7:0]);
    send_byte(n16[15:8]);
    for (int i = 0; i < fw.size(); i++) begin
      w = fw[i];
      for (int k = 0; k < 4; k++) begin
        s = s + w[k*8 +: 8];
        send_byte(w[k*8 +: 8]);
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(bad_cs ? s + 8'd1 : s);
`endif
  endtask

  task automatic send_frame();
    send_byte(8'hA5);
    send_body();
  endtask

  task automatic expect_load(input string tag);
    int n;
    logic [63:0] e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cpu_hold && n < 40);
    check({tag, "_hold"}, {31'd0, cpu_hold}, 32'd0);
    check({tag, "_latency"}, cyc - last_acc, 32'd2);
    check({tag, "_done"}, {31'd0, load_done}, 32'd1);
    check({tag, "_err"}, {31'd0, load_err}, 32'd0);
    check({tag, "_nwrites"}, wq.size(), fw.size());
    for (int i = 0; i < fw.size() && i < wq.size(); i++) begin
      e = wq[i];
      check($sformatf("%s_addr%0d", tag, i), e[63:32], 32'(i * 4));
      check($sformatf("%s_data%0d", tag, i), e[31:0], fw[i]);
    end
  endtask

  task automatic expect_err(input string tag, input int nwr);
    repeat (3) @(negedge clk);
    check({tag, "_err"}, {31'd0, load_err}, 32'd1);
    check({tag, "_done"}, {31'd0, load_done}, 32'd0);
    check({tag, "_hold"}, {31'd0, cpu_hold}, 32'd1);
    check({tag, "_nwrites"}, wq.size(), nwr);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd1);
    check({tag, "_we"}, {31'd0, imem_we}, 32'd0);
    check({tag, "_waddr"}, imem_waddr, 32'd0);
    check({tag, "_wdata"}, imem_wdata, 32'd0);
    check({tag, "_hold"}, {31'd0, cpu_hold}, 32'd1);
    check({tag, "_done"}, {31'd0, load_done}, 32'd0);
    check({tag, "_err"}, {31'd0, load_err}, 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Garbage before any sync byte is discarded.
    wq.delete();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    @(negedge clk);
    check("garbage_nwrites", wq.size(), 0);
    check("garbage_hold", {31'd0, cpu_hold}, 32'd1);

    // Two-word image.
    fw = '{32'h00000013, 32'h00100093};
    send_frame();
    expect_load("two_word");

    // Garbage in RUN is ignored, SYNC restarts loading.
    wq.delete();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    check("run_garbage_hold", {31'd0, cpu_hold}, 32'd0);
    send_byte(8'hA5);
    @(negedge clk);
    check("restart_hold", {31'd0, cpu_hold}, 32'd1);
    check("restart_done", {31'd0, load_done}, 32'd0);
    fw = '{32'hDEADBEEF};
    send_body();
    expect_load("reload");

    // Count above capacity.
    wq.delete();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h04);
    expect_err("n1025", 0);

    // A good frame clears the error.
    wq.delete();
    fw = '{32'h12345678};
    send_frame();
    expect_load("recover");

    // Zero count.
    wq.delete();
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    expect_err("n0", 0);

    // Exactly full capacity is accepted.
    wq.delete();
    fw.delete();
    for (int i = 0; i < 1024; i++) fw.push_back(32'(i) * 32'h00010001 + 32'h0F0F0000);
    send_frame();
    expect_load("n1024");

    // Reset in the middle of a frame.
    wq.delete();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midrst");
    check("midrst_nwrites", wq.size(), 0);
    rst = 1'b0;
    fw = '{32'h00000013};
    send_frame();
    expect_load("post_rst");

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong checksum: word is written but the image is rejected.
    wq.delete();
    fw = '{32'h00000013};
    bad_cs = 1'b1;
    send_frame();
    bad_cs = 1'b0;
    expect_err("cs_bad", 1);
    wq.delete();
    send_frame();
    expect_load("cs_good");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/imem_loader_ctrl.md
# imem_loader_ctrl

Boot-time program loader and fetch-hold controller for the instruction memory. Receives a framed byte stream (from the UART receiver), assembles little-endian 32-bit words, and writes them through the IMEM write port while holding the core's fetch. Releases the core once a complete, valid image is stored. Sits between the UART RX block, the IMEM write port and the core's PC/fetch stall input.

## Interface
- `DEPTH_WORDS`, 1024: IMEM capacity in 32-bit words; maximum accepted image length.
- `SYNC_BYTE`, 8'hA5: frame start byte.
- `clk`  input  1  system clock.
- `rst`  input  1  synchronous, active-high reset.
- `rx_valid`  input  1  byte available on `rx_data`.
- `rx_data`  input  8  received byte.
- `rx_ready`  output  1  a byte is accepted in any cycle where `rx_valid && rx_ready`.
- `imem_we`  output  1  one-cycle IMEM word write strobe.
- `imem_waddr`  output  32  byte address of the write; always word-aligned (bits [1:0] = 0).
- `imem_wdata`  output  32  word to write.
- `cpu_hold`  output  1  holds the core's PC at 0 and suppresses fetch.
- `load_done`  output  1  level; a valid image is loaded and the core is running.
- `load_err`  output  1  level; the last frame was rejected.

## Operation
- Frame format: `SYNC_BYTE`, count low byte, count high byte (N words), then 4N data bytes, each word sent LSB first. With the checksum feature compiled in, a checksum byte follows.
- States:
  - SYNC: discards bytes other than `SYNC_BYTE`. On `SYNC_BYTE`, go to CNT0.
  - CNT0: capture the low count byte, go to CNT1.
  - CNT1: capture the high count byte. If N == 0 or N > `DEPTH_WORDS`, go to ERR. Otherwise clear the word index and byte lane, then go to DATA.
  - DATA: place each accepted byte in lane 0..3 of the word register. When lane 3 is accepted, go to WRITE.
  - WRITE: lasts one cycle. `imem_we`=1, `imem_waddr`={index, 2'b00}, `rx_ready`=0. Then:
    - if index == N-1: go to CHK (feature in) or DONE (feature out);
    - otherwise increment index and return to DATA.
  - CHK: accept one byte. If it matches, go to DONE; otherwise go to ERR.
  - DONE: lasts one cycle. Set `load_done`, clear `load_err`, go to RUN.
  - RUN: `cpu_hold`=0. A `SYNC_BYTE` restarts loading: `cpu_hold`=1, `load_done`=0, go to CNT0. All other bytes are discarded.
  - ERR: lasts one cycle. Set `load_err`, clear `load_done`, go to SYNC.
- `rx_ready`=1 in every state except WRITE, DONE and ERR.
- `cpu_hold`=1 in every state except RUN.
- Count is 16-bit unsigned. The word index is 16-bit and never exceeds N-1, so there is no wrap-around.
- Once rejected, a frame is never partially resumed. Words already written before an error remain in IMEM, but the core stays held.

## Timing
- Reset values: `rx_ready`=1, `imem_we`=0, `imem_waddr`=0, `imem_wdata`=0, `cpu_hold`=1, `load_done`=0, `load_err`=0. State is SYNC.
- Reset asserted mid-frame aborts the frame on the next `clk` edge; the outputs take their reset values.
- `imem_we` is high exactly in the cycle after the 4th byte of a word is accepted. `imem_wdata` is registered and stable during that cycle.
- `cpu_hold` falls in the cycle after DONE, i.e. 2 cycles after the final byte (last data byte, or checksum byte) is accepted.
- `cpu_hold` rises in the cycle after a `SYNC_BYTE` is accepted in RUN.
- Back-to-back bytes are supported. The maximum throughput is 4 bytes per 5 cycles.

## Configuration
- Macro: `IMEM_LOADER_CHECKSUM_EN`.
- Defined: an 8-bit running sum (mod 256) of all 4N data bytes is kept. The trailing byte must equal the sum; a mismatch goes to ERR.
- Undefined: there is no CHK state and no sum register. WRITE of the last word goes directly to DONE.

## Structure
- Package `imem_loader_pkg` holds:
  - the state enum type (SYNC, CNT0, CNT1, DATA, WRITE, CHK, DONE, RUN, ERR);
  - the `SYNC_BYTE` default constant;
  - a `NOP_INSN` constant 32'h00000013.
- Sub-module `imem_word_packer`: lane counter plus 4×8 shift/placement into a 32-bit word, with a `word_valid` pulse. The FSM and address counter stay in the top module.

## Test plan
- Reset, then send A5 02 00 13 00 00 00 93 00 10 00. Required response:
  - `imem_we` pulses twice: address 0x0 with data 0x00000013, then address 0x4 with data 0x00100093.
  - `load_done`=1, and `cpu_hold` falls 2 cycles after the last byte.
- Send garbage bytes 00 FF 5A before A5 01 00 …: the garbage produces no write, and the load completes normally.
- Send count 0 (A5 00 00), then count 1025 (A5 01 04): each frame causes `load_err`=1 with no `imem_we`, and `cpu_hold` stays 1.
- While in RUN, send A5: `cpu_hold` rises the next cycle and `load_done` clears. A following 1-word frame reloads address 0.
- Assert `rst` after 6 bytes of a frame: all outputs take reset values and the state returns to SYNC. A fresh frame then loads correctly.
- With `IMEM_LOADER_CHECKSUM_EN`, send a 1-word frame with data 0x00000013:
  - checksum 0x13: the load succeeds;
  - checksum 0x14: `load_err`=1 and `cpu_hold` stays 1.
